dispatch_reservation_station: RTL

- Consumer end of the rename→dispatch interface.
- Accepts one `disp_packet_t` (from `CORE_PKG`) per cycle into an RS_ENTRIES-deep reservation station.
- Tracks source-operand readiness via a single writeback wakeup bus.
- Issues the oldest fully-ready entry to one functional unit using a valid/ready handshake. One instance sits in front of each FU (NUM_FUS instances total).

---
 rtl/dispatch_reservation_station.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dispatch_reservation_station.sv
// Dispatch-side reservation station: captures renamed packets, tracks operand
// readiness through a single writeback wakeup bus, and presents the oldest
// fully-ready entry to one functional unit.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both 1. Dispatch uses
// disp_pkt.instr_valid / disp_ready; issue uses iss_valid / iss_ready.
// The producer holds its payload while valid=1 and ready=0. ready never
// depends on valid in the same cycle.

package core_pkg;
  // 83-bit rename->dispatch packet
  typedef struct packed {
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] imm_val;
    logic [5:0]  dst_preg;
    logic [5:0]  src1_preg;
    logic [5:0]  src2_preg;
  } disp_packet_t;
endpackage

module dispatch_reservation_station
  import core_pkg::*;
#(
  parameter int RS_ENTRIES = 4,
  parameter int NUM_PREGS  = 64,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int AGE_W     = $clog2(RS_ENTRIES) + 1,
  localparam int IDX_W     = $clog2(RS_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  disp_packet_t      disp_pkt,
  input  logic              disp_src1_rdy,
  input  logic              disp_src2_rdy,
  output logic              disp_ready,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [PREG_W-1:0] iss_dst_preg,
  output logic [PREG_W-1:0] iss_src1_preg,
  output logic [PREG_W-1:0] iss_src2_preg,
  output logic [31:0]       iss_imm,
  output logic [31:0]       iss_pc,
  output logic [AGE_W-1:0]  occupancy
);

  logic         ent_valid [RS_ENTRIES];
  logic         ent_s1_rdy[RS_ENTRIES];
  logic         ent_s2_rdy[RS_ENTRIES];
  disp_packet_t ent_pkt   [RS_ENTRIES];
  logic [AGE_W-1:0] ent_age[RS_ENTRIES];
  logic [AGE_W-1:0] seq_cnt;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;
  logic [AGE_W-1:0] age_diff;
  logic             disp_fire;
  logic             iss_fire;
  logic             cap_s1_rdy;
  logic             cap_s2_rdy;

  // Occupancy as a population count of valid bits, so it can never drift
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      occupancy = occupancy + AGE_W'(ent_valid[i]);
    end
  end

  assign disp_ready = (occupancy < AGE_W'(RS_ENTRIES));
  assign disp_fire  = disp_pkt.instr_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready;

  // Operand readiness at capture, including a same-cycle writeback
  assign cap_s1_rdy = disp_src1_rdy || (wb_valid && (wb_preg == disp_pkt.src1_preg));
  assign cap_s2_rdy = disp_src2_rdy || (wb_valid && (wb_preg == disp_pkt.src2_preg));

  // Lowest-index free entry for dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest-ready select; a negative wrap-aware difference means "older"
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    age_diff  = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      age_diff = ent_age[i] - sel_age;
      if (ent_valid[i] && ent_s1_rdy[i] && ent_s2_rdy[i] &&
          (!sel_found || age_diff[AGE_W-1])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_age[i];
      end
    end
  end

  // Issue outputs are zero whenever nothing is presented
  always_comb begin
    iss_valid     = sel_found;
    iss_dst_preg  = '0;
    iss_src1_preg = '0;
    iss_src2_preg = '0;
    iss_imm       = '0;
    iss_pc        = '0;
    if (sel_found) begin
      iss_dst_preg  = ent_pkt[sel_idx].dst_preg;
      iss_src1_preg = ent_pkt[sel_idx].src1_preg;
      iss_src2_preg = ent_pkt[sel_idx].src2_preg;
      iss_imm       = ent_pkt[sel_idx].imm_val;
      iss_pc        = ent_pkt[sel_idx].pc;
    end
  end

  // Entry state: flush beats everything; otherwise wakeup, issue, dispatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_s1_rdy[i] <= 1'b0;
        ent_s2_rdy[i] <= 1'b0;
        ent_pkt[i]    <= '0;
        ent_age[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        ent_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (ent_valid[i] && wb_valid && (ent_pkt[i].src1_preg == wb_preg)) begin
          ent_s1_rdy[i] <= 1'b1;
        end
        if (ent_valid[i] && wb_valid && (ent_pkt[i].src2_preg == wb_preg)) begin
          ent_s2_rdy[i] <= 1'b1;
        end
      end
      if (iss_fire) begin
        ent_valid[sel_idx] <= 1'b0;
      end
      // The free slot is never the issuing slot, so these writes don't collide
      if (disp_fire && free_found) begin
        ent_valid[free_idx]  <= 1'b1;
        ent_s1_rdy[free_idx] <= cap_s1_rdy;
        ent_s2_rdy[free_idx] <= cap_s2_rdy;
        ent_pkt[free_idx]    <= disp_pkt;
        ent_age[free_idx]    <= seq_cnt;
        seq_cnt              <= seq_cnt + 1'b1;
      end
    end
  end

endmodule
